branch_resolve_unit: RTL

- Pipelined branch/jump resolution stage that sits between the execute operand muxes and the fetch redirect path.
- Evaluates all six RV32/64 conditional branch compares, plus JAL and JALR.
- Computes target and link address, and compares the outcome against the fetch-stage prediction.
- Holds the result in an output register with valid/ready handshake, flush, and saturating performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 19 +
 rtl/branch_cond_eval.sv | 24 ++
 rtl/branch_resolve_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared branch condition codes and registered result layout
package branch_resolve_unit_pkg;
  localparam int XLEN_MAX = 64;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  typedef struct packed {
    logic                taken;
    logic [XLEN_MAX-1:0] target;
    logic [XLEN_MAX-1:0] link;
    logic                mispredict;
    logic [XLEN_MAX-1:0] redirect;
    logic                misaligned;
    logic                illegal;
  } bru_result_t;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational RV conditional-branch compare with illegal-encoding flag
module branch_cond_eval import branch_resolve_unit_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            taken,
  output logic            illegal
);
  logic eq, lt, ltu;
  always_comb begin
    eq      = src_a == src_b;
    lt      = $signed(src_a) < $signed(src_b);
    ltu     = src_a < src_b;
    illegal = funct3 == 3'b010 || funct3 == 3'b011;
    taken   = funct3 == BR_EQ  ? eq :
              funct3 == BR_NE  ? !eq :
              funct3 == BR_LT  ? lt :
              funct3 == BR_GE  ? !lt :
              funct3 == BR_LTU ? ltu :
              funct3 == BR_GEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution with prediction check and retire counters
module branch_resolve_unit import branch_resolve_unit_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int COMPRESSED = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic             IsBranch,
  input  logic             IsJal,
  input  logic             IsJalr,
  input  logic [2:0]       Funct3,
  input  logic [XLEN-1:0]  SrcA,
  input  logic [XLEN-1:0]  SrcB,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  Imm,
  input  logic             PredTaken,
  input  logic [XLEN-1:0]  PredTarget,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Taken,
  output logic [XLEN-1:0]  Target,
  output logic [XLEN-1:0]  LinkAddr,
  output logic             Mispredict,
  output logic [XLEN-1:0]  RedirectPC,
  output logic             Misaligned,
  output logic             Illegal,
  input  logic             CountClear,
  output logic [CNT_W-1:0] CtrlCount,
  output logic [CNT_W-1:0] MispredCount
);
  logic cond_taken, cond_illegal;
  logic multi, one_hot, illegal, taken, accept, handshake, inc;
  logic [XLEN-1:0] target, link;
  bru_result_t nxt, res_d, res_q;
  logic valid_d, valid_q, ctrl_d, ctrl_q;
  logic [CNT_W-1:0] ctrl_cnt_d, ctrl_cnt_q, misp_cnt_d, misp_cnt_q;
  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3 (Funct3),
    .src_a  (SrcA),
    .src_b  (SrcB),
    .taken  (cond_taken),
    .illegal(cond_illegal)
  );
  always_comb begin
    multi          = (IsBranch && IsJal) || (IsBranch && IsJalr) || (IsJal && IsJalr);
    one_hot        = (IsBranch || IsJal || IsJalr) && !multi;
    illegal        = multi || (IsBranch && one_hot && cond_illegal);
    taken          = one_hot && !illegal && (!IsBranch || cond_taken);
    target         = IsJalr ? (SrcA + Imm) & ~XLEN'(1) : PC + Imm;
    link           = PC + XLEN'(4);
    InReady        = rst_n && !Flush && (!valid_q || OutReady);
    accept         = InValid && InReady;
    handshake      = valid_q && OutReady && !Flush;
    inc            = handshake && ctrl_q;
    nxt.taken      = taken;
    nxt.target     = XLEN_MAX'(target);
    nxt.link       = XLEN_MAX'(link);
    nxt.mispredict = one_hot && !illegal && (taken != PredTaken || (taken && PredTarget != target));
    nxt.redirect   = XLEN_MAX'(taken ? target : link);
    nxt.misaligned = taken && (COMPRESSED != 0 ? target[0] : |target[1:0]);
    nxt.illegal    = illegal;
    res_d          = accept ? nxt : res_q;
    ctrl_d         = accept ? one_hot && !illegal : ctrl_q;
    valid_d        = !Flush && (accept || (valid_q && !OutReady));
    ctrl_cnt_d     = CountClear ? '0 : inc && !(&ctrl_cnt_q) ? ctrl_cnt_q + CNT_W'(1) : ctrl_cnt_q;
    misp_cnt_d     = CountClear ? '0 : inc && res_q.mispredict && !(&misp_cnt_q) ? misp_cnt_q + CNT_W'(1) : misp_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      res_q      <= '0;
      ctrl_q     <= 1'b0;
      ctrl_cnt_q <= '0;
      misp_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      res_q      <= res_d;
      ctrl_q     <= ctrl_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end
  if (XLEN < XLEN_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{res_q.target[XLEN_MAX-1:XLEN], res_q.link[XLEN_MAX-1:XLEN], res_q.redirect[XLEN_MAX-1:XLEN]};
  end
  assign OutValid     = valid_q;
  assign Taken        = res_q.taken;
  assign Target       = res_q.target[XLEN-1:0];
  assign LinkAddr     = res_q.link[XLEN-1:0];
  assign Mispredict   = res_q.mispredict;
  assign RedirectPC   = res_q.redirect[XLEN-1:0];
  assign Misaligned   = res_q.misaligned;
  assign Illegal      = res_q.illegal;
  assign CtrlCount    = ctrl_cnt_q;
  assign MispredCount = misp_cnt_q;
endmodule
